// File: rtl/eth_mac_tx_arbiter.sv
// Frame-granular AXI-stream arbiter in front of the MAC TX FIFO.
// Grants whole frames (round-robin or fixed priority) and truncates oversize frames, marking them bad.
module eth_mac_tx_arbiter #(
  parameter int S_COUNT         = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int KEEP_ENABLE     = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH      = (DATA_WIDTH / 8),
  parameter int ARB_ROUND_ROBIN = 1,
  parameter int MAX_FRAME_BEATS = 1518
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          enable,
  output logic [S_COUNT-1:0]            grant,
  output logic                          grant_valid,
  output logic                          truncated
);

  localparam int IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
  localparam bit TRUNC_EN = (MAX_FRAME_BEATS != 0);
  localparam logic [15:0] TRUNC_AT = 16'((MAX_FRAME_BEATS > 0) ? MAX_FRAME_BEATS - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [S_COUNT-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [15:0]            beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
  logic [KEEP_WIDTH-1:0]  m_tkeep_q, m_tkeep_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic                   m_tlast_q, m_tlast_d;
  logic                   m_tuser_q, m_tuser_d;
  logic                   truncated_q, truncated_d;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       cand_idx;
  int                     search_idx;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [KEEP_WIDTH-1:0]  sel_keep;
  logic                   sel_valid, sel_last, sel_user;
  logic [IDX_W-1:0]       next_ptr;
  logic                   out_ready;
  logic                   accept;

  // Winner search starts at the RR pointer (or at 0 for fixed priority) and wraps.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand_idx   = '0;
    search_idx = 0;
    for (int i = 0; i < S_COUNT; i++) begin
      search_idx = (ARB_ROUND_ROBIN != 0) ? int'(rr_ptr_q) + i : i;
      if (search_idx >= S_COUNT) search_idx = search_idx - S_COUNT;
      cand_idx = IDX_W'(search_idx);
      if (!win_found && s_axis_tvalid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    next_ptr  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_q[i]) begin
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_user  = s_axis_tuser[i];
        next_ptr  = (i == S_COUNT - 1) ? '0 : IDX_W'(i + 1);
      end
    end
  end

  assign out_ready = m_axis_tready | ~m_tvalid_q;

  always_comb begin
    s_axis_tready = '0;
    accept        = 1'b0;
    if (state_q == ACTIVE) begin
      s_axis_tready = grant_q & {S_COUNT{out_ready}};
      accept        = sel_valid & out_ready;
    end else if (state_q == DRAIN) begin
      s_axis_tready = grant_q;
      accept        = sel_valid;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    m_tdata_d   = m_tdata_q;
    m_tkeep_d   = m_tkeep_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_tuser_d   = m_tuser_q;
    truncated_d = 1'b0;

    if (m_tvalid_q && m_axis_tready) m_tvalid_d = 1'b0;
    if (accept && beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          state_d    = ACTIVE;
          grant_d    = {{(S_COUNT-1){1'b0}}, 1'b1} << win_idx;
          beat_cnt_d = '0;
        end
      end
      ACTIVE: begin
        if (accept) begin
          m_tdata_d  = sel_data;
          m_tkeep_d  = sel_keep;
          m_tvalid_d = 1'b1;
          m_tlast_d  = sel_last;
          m_tuser_d  = sel_user;
          if (sel_last) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = next_ptr;
          end else if (TRUNC_EN && beat_cnt_q == TRUNC_AT) begin
            // Close the frame early and mark it bad; the rest of the source frame is swallowed.
            m_tlast_d   = 1'b1;
            m_tuser_d   = 1'b1;
            truncated_d = 1'b1;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && sel_last) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tuser_q   <= 1'b0;
      truncated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tuser_q   <= m_tuser_d;
      truncated_q <= truncated_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? m_tkeep_q : {KEEP_WIDTH{1'b1}};
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign grant         = grant_q;
  assign grant_valid   = (state_q != IDLE);
  assign truncated     = truncated_q;

endmodule

// File: tb/tb_eth_mac_tx_arbiter.sv
// Scoreboard bench for eth_mac_tx_arbiter: per-port source queues feed the DUT,
// expected output beats are queued in grant order and checked as they leave m_axis.
module tb_eth_mac_tx_arbiter;

  localparam int S_COUNT = 4;
  localparam int DW      = 8;
  localparam int KW      = 1;
  localparam int MAX     = 100;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [S_COUNT*DW-1:0]  s_axis_tdata;
  logic [S_COUNT*KW-1:0]  s_axis_tkeep;
  logic [S_COUNT-1:0]     s_axis_tvalid;
  logic [S_COUNT-1:0]     s_axis_tready;
  logic [S_COUNT-1:0]     s_axis_tlast;
  logic [S_COUNT-1:0]     s_axis_tuser;
  logic [DW-1:0]          m_axis_tdata;
  logic [KW-1:0]          m_axis_tkeep;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;
  logic                   m_axis_tuser;
  logic                   enable = 1'b1;
  logic [S_COUNT-1:0]     grant;
  logic                   grant_valid;
  logic                   truncated;

  beat_t        src_q[S_COUNT][$];
  beat_t        sb_q[$];
  logic [3:0]   grant_log[$];
  int           cmp_cnt = 0;
  int           fail_cnt = 0;
  int           out_beats = 0;
  int           trunc_pulses = 0;
  int           p1_left_at_g3 = -1;
  bit           bubble_en = 1'b0;
  bit           toggle_ready = 1'b0;
  logic [S_COUNT-1:0] acc;
  logic         prev_gv;

  eth_mac_tx_arbiter #(
    .S_COUNT(S_COUNT), .DATA_WIDTH(DW), .KEEP_ENABLE(0), .KEEP_WIDTH(KW),
    .ARB_ROUND_ROBIN(1), .MAX_FRAME_BEATS(MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .enable(enable), .grant(grant), .grant_valid(grant_valid), .truncated(truncated)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one source frame and the beats the MAC side should see for it.
  task automatic applyStimulus(input int port, input int len, input logic user);
    beat_t b;
    beat_t e;
    for (int i = 0; i < len; i++) begin
      b.data = 8'($urandom_range(0, 255));
      b.last = (i == len - 1);
      b.user = b.last ? user : 1'b0;
      src_q[port].push_back(b);
      if (i < MAX) begin
        e = b;
        if (len > MAX && i == MAX - 1) begin
          e.last = 1'b1;
          e.user = 1'b1;
        end
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic clearStats();
    out_beats     = 0;
    trunc_pulses  = 0;
    p1_left_at_g3 = -1;
    grant_log.delete();
  endtask

  task automatic clearQueues();
    for (int p = 0; p < S_COUNT; p++) src_q[p].delete();
    sb_q.delete();
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clearQueues();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearStats();
  endtask

  task automatic waitIdle(input string tag, input int budget);
    bit done;
    bit empty;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      empty = (sb_q.size() == 0) && !grant_valid && !m_axis_tvalid;
      for (int p = 0; p < S_COUNT; p++) if (src_q[p].size() != 0) empty = 1'b0;
      if (empty) done = 1'b1;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkGrants(input string tag, input logic [31:0] seq, input int n);
    checkOutput({tag, "_count"}, 32'(grant_log.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < grant_log.size())
        checkOutput($sformatf("%s_%0d", tag, i), 32'(grant_log[i]), 32'(seq[4*i +: 4]));
  endtask

  // Source drivers, MAC-side ready, and output monitor in one clocked loop.
  initial begin
    acc           = '0;
    prev_gv       = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '1;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      for (int p = 0; p < S_COUNT; p++) begin
        if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (src_q[p].size() > 0 &&
            ((s_axis_tvalid[p] && !acc[p]) || !bubble_en || $urandom_range(0, 3) != 0)) begin
          s_axis_tvalid[p]          = 1'b1;
          s_axis_tdata[p*DW +: DW]  = src_q[p][0].data;
          s_axis_tlast[p]           = src_q[p][0].last;
          s_axis_tuser[p]           = src_q[p][0].user;
        end else begin
          s_axis_tvalid[p] = 1'b0;
          s_axis_tlast[p]  = 1'b0;
          s_axis_tuser[p]  = 1'b0;
        end
      end
      m_axis_tready = toggle_ready ? ~m_axis_tready : 1'b1;
      #4;
      acc = s_axis_tvalid & s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        logic [31:0] exp_beat;
        out_beats++;
        exp_beat = (sb_q.size() > 0) ? 32'(sb_q.pop_front()) : 32'hFFFF_FFFF;
        checkOutput("beat", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), exp_beat);
      end
      if (truncated) trunc_pulses++;
      if (grant_valid && !prev_gv) begin
        grant_log.push_back(grant);
        if (grant == 4'b1000) p1_left_at_g3 = src_q[1].size();
      end
      prev_gv = grant_valid;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    checkOutput("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    checkOutput("rst_m_tuser", 32'(m_axis_tuser), 32'd0);
    checkOutput("rst_s_tready", 32'(s_axis_tready), 32'd0);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("rst_truncated", 32'(truncated), 32'd0);
    rst = 1'b0;
    clearStats();

    $display("[TB] two simultaneous 64-beat frames");
    applyStimulus(0, 64, 1'b0);
    applyStimulus(2, 64, 1'b0);
    waitIdle("t1", 2000);
    checkOutput("t1_beats", 32'(out_beats), 32'd128);
    checkGrants("t1_grant", 32'h41, 2);

    $display("[TB] round-robin rotation");
    resetDut();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < S_COUNT; p++) applyStimulus(p, 4, 1'b0);
    waitIdle("t2", 2000);
    checkOutput("t2_beats", 32'(out_beats), 32'd32);
    checkGrants("t2_grant", 32'h8421_8421, 8);

    $display("[TB] oversize frame truncation");
    resetDut();
    applyStimulus(1, 150, 1'b0);
    for (int c = 0; c < 100 && grant_log.size() == 0; c++) @(negedge clk);
    applyStimulus(3, 5, 1'b1);
    waitIdle("t3", 2000);
    checkOutput("t3_beats", 32'(out_beats), 32'd105);
    checkOutput("t3_trunc_pulses", 32'(trunc_pulses), 32'd1);
    checkOutput("t3_p1_left_at_g3", 32'(p1_left_at_g3), 32'd0);
    checkGrants("t3_grant", 32'h82, 2);

    $display("[TB] frame of exactly max length");
    resetDut();
    applyStimulus(0, MAX, 1'b0);
    waitIdle("t4", 2000);
    checkOutput("t4_beats", 32'(out_beats), 32'(MAX));
    checkOutput("t4_trunc_pulses", 32'(trunc_pulses), 32'd0);

    $display("[TB] backpressure and source bubbles");
    resetDut();
    bubble_en    = 1'b1;
    toggle_ready = 1'b1;
    applyStimulus(0, 10, 1'b1);
    applyStimulus(1, 30, 1'b0);
    applyStimulus(3, 20, 1'b1);
    waitIdle("t5", 3000);
    bubble_en    = 1'b0;
    toggle_ready = 1'b0;
    checkOutput("t5_beats", 32'(out_beats), 32'd60);
    checkGrants("t5_grant", 32'h821, 3);

    $display("[TB] enable dropped mid-frame");
    resetDut();
    applyStimulus(2, 40, 1'b0);
    for (int c = 0; c < 500 && out_beats < 10; c++) @(negedge clk);
    enable = 1'b0;
    applyStimulus(1, 5, 1'b0);
    for (int c = 0; c < 500 && !(sb_q.size() == 5 && !grant_valid && !m_axis_tvalid); c++)
      @(negedge clk);
    repeat (20) @(negedge clk);
    checkOutput("t6_gv_disabled", 32'(grant_valid), 32'd0);
    checkOutput("t6_p1_waiting", 32'(src_q[1].size()), 32'd5);
    checkOutput("t6_beats_disabled", 32'(out_beats), 32'd40);
    enable = 1'b1;
    waitIdle("t6", 1000);
    checkGrants("t6_grant", 32'h24, 2);

    $display("[TB] reset mid-frame");
    resetDut();
    applyStimulus(0, 50, 1'b0);
    for (int c = 0; c < 500 && out_beats < 10; c++) @(negedge clk);
    checkOutput("t7_reached_beat10", 32'(out_beats >= 10), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t7_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("t7_m_tdata", 32'(m_axis_tdata), 32'd0);
    checkOutput("t7_m_tlast", 32'(m_axis_tlast), 32'd0);
    checkOutput("t7_s_tready", 32'(s_axis_tready), 32'd0);
    checkOutput("t7_grant", 32'(grant), 32'd0);
    checkOutput("t7_grant_valid", 32'(grant_valid), 32'd0);
    clearQueues();
    @(negedge clk);
    rst = 1'b0;
    clearStats();
    applyStimulus(3, 3, 1'b0);
    waitIdle("t7", 500);
    checkGrants("t7_grant_after", 32'h8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
